// File: rtl/booth_op_sequencer.sv
// Operand sequencer around a Booth multiplier datapath/controller pair.
// Buffers operand pairs in a small FIFO, issues one multiply at a time with
// operands held stable, captures the 2N-bit product and presents it on a
// valid/ready output stream. A watchdog abandons operations whose done never
// arrives and raises a sticky error flag.
module booth_op_sequencer #(
  parameter int unsigned N       = 8,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N-1:0]   in_mcand_i,
  input  logic [N-1:0]   in_mplier_i,
  output logic           mul_start_o,
  output logic [N-1:0]   mul_m_o,
  output logic [N-1:0]   mul_q_o,
  input  logic           mul_done_i,
  input  logic [2*N-1:0] mul_product_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*N-1:0] out_product_o,
  output logic           busy_o,
  output logic           err_timeout_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StOut} state_e;

  state_e state_q;

  // FIFO storage: each entry is {multiplicand, multiplier}
  logic [2*N-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  logic [2*N-1:0]  head;

  logic [WdW-1:0]  wdog_q;

  assign in_ready_o = (count_q < CntFull);
  assign busy_o     = (state_q != StIdle) || (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

  // FIFO pointer/occupancy next state; pops only happen while the FSM idles
  always_comb begin
    push     = in_valid_i && in_ready_o;
    pop      = (state_q == StIdle) && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // FIFO state; reset discards every queued entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {in_mcand_i, in_mplier_i};
      end
    end
  end

  // Operation sequencer with registered handshake/datapath outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      mul_start_o   <= 1'b0;
      mul_m_o       <= '0;
      mul_q_o       <= '0;
      out_valid_o   <= 1'b0;
      out_product_o <= '0;
      err_timeout_o <= 1'b0;
      wdog_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            // Operands only ever change here, so they stay put through START..OUT
            mul_m_o     <= head[2*N-1:N];
            mul_q_o     <= head[N-1:0];
            mul_start_o <= 1'b1;
            state_q     <= StStart;
          end
        end
        StStart: begin
          mul_start_o <= 1'b0;
          wdog_q      <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          // done takes priority over an expiring watchdog in the same cycle
          if (mul_done_i) begin
            out_product_o <= mul_product_i;
            out_valid_o   <= 1'b1;
            state_q       <= StOut;
          end else if (wdog_q == WdLast) begin
            err_timeout_o <= 1'b1;
            state_q       <= StIdle;
          end else begin
            wdog_q <= wdog_q + WdW'(1);
          end
        end
        StOut: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Scoreboard bench for booth_op_sequencer with a small behavioural multiplier.
module tb_booth_op_sequencer;

  localparam int N       = 8;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_mcand = '0;
  logic [N-1:0]  in_mplier = '0;
  logic          mul_start;
  logic [N-1:0]  mul_m;
  logic [N-1:0]  mul_q;
  logic          mul_done;
  logic [2*N-1:0] mul_product;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*N-1:0] out_product;
  logic          busy;
  logic          err_timeout;

  always #5 clk = ~clk;

  booth_op_sequencer #(
    .N       (N),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_mcand_i    (in_mcand),
    .in_mplier_i   (in_mplier),
    .mul_start_o   (mul_start),
    .mul_m_o       (mul_m),
    .mul_q_o       (mul_q),
    .mul_done_i    (mul_done),
    .mul_product_i (mul_product),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_product_o (out_product),
    .busy_o        (busy),
    .err_timeout_o (err_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*N-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Multiplier model: done LAT+1 cycles after start; one chosen start can be ignored
  logic           model_done = 1'b0;
  logic [2*N-1:0] model_prod = '0;
  logic           force_done = 1'b0;
  logic           pend = 1'b0;
  int             cnt = 0;
  int             nstarts = 0;
  int             hang_idx = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_done <= 1'b0;
      pend       <= 1'b0;
      cnt        <= 0;
    end else begin
      model_done <= 1'b0;
      if (mul_start) begin
        nstarts <= nstarts + 1;
        if (nstarts != hang_idx) begin
          pend <= 1'b1;
          cnt  <= LAT;
        end
      end else if (pend) begin
        if (cnt == 0) begin
          model_done <= 1'b1;
          model_prod <= {{N{mul_m[N-1]}}, mul_m} * {{N{mul_q[N-1]}}, mul_q};
          pend       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  assign mul_done    = model_done | force_done;
  assign mul_product = force_done ? 16'hDEAD : model_prod;

  // Monitor: every accepted output must match the oldest expected product
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %0h expected none", out_product);
      end else begin
        check("scoreboard", {16'h0, out_product}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return out_valid;
      1:       return mul_start;
      2:       return !busy;
      3:       return in_ready;
      default: return 1'b0;
    endcase
  endfunction

  // Advance to negedges until the selected condition holds (bounded)
  task automatic wait_for(input int sel, input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sig(sel) && k < 300);
    if (!sig(sel)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout expected condition", name);
    end
  endtask

  // Call just after a posedge; returns just after the accepting posedge
  task automatic push(input logic [N-1:0] m, input logic [N-1:0] q,
                      input logic [2*N-1:0] exp, input bit expect_out);
    in_valid  = 1'b1;
    in_mcand  = m;
    in_mplier = q;
    wait_for(3, "push_ready");
    @(posedge clk);
    if (expect_out) exp_q.push_back(exp);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset values
    #1;
    check("rst_start", mul_start, 0);
    check("rst_valid", out_valid, 0);
    check("rst_product", out_product, 0);
    check("rst_err", err_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_m", mul_m, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_in_ready", in_ready, 1);

    // Single op: start timing, held output under backpressure
    push(8'h03, 8'hFC, 16'hFFF4, 1'b1);
    @(negedge clk) check("start_t1", mul_start, 0);
    @(negedge clk) check("start_t2", mul_start, 1);
    check("start_m", mul_m, 8'h03);
    check("start_q", mul_q, 8'hFC);
    @(negedge clk) check("start_t3", mul_start, 0);
    wait_for(0, "t1_valid");
    repeat (3) @(negedge clk);
    check("hold_valid", out_valid, 1);
    check("hold_product", out_product, 16'hFFF4);
    check("operand_hold", mul_m, 8'h03);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_for(2, "t1_idle");

    // Corner products
    @(posedge clk);
    #1;
    push(8'h80, 8'h80, 16'h4000, 1'b1);
    push(8'h7F, 8'h80, 16'hC080, 1'b1);
    wait_for(2, "t2_idle");
    check("t2_drained", exp_q.size(), 0);

    // Backpressure: one in flight, DEPTH queued, then full
    @(posedge clk);
    #1 out_ready = 1'b0;
    push(8'h05, 8'h06, 16'h001E, 1'b1);
    push(8'hFF, 8'hFF, 16'h0001, 1'b1);
    push(8'h0A, 8'hF6, 16'hFF9C, 1'b1);
    in_valid  = 1'b1;
    in_mcand  = 8'h7F;
    in_mplier = 8'h7F;
    @(negedge clk) check("bp_full", in_ready, 0);
    repeat (8) @(negedge clk);
    check("bp_still_full", in_ready, 0);
    check("bp_head_valid", out_valid, 1);
    check("bp_head_product", out_product, 16'h001E);
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    push(8'h7F, 8'h7F, 16'h3F01, 1'b1);
    wait_for(2, "bp_idle");
    check("bp_drained", exp_q.size(), 0);

    // Watchdog: first op never completes, queued op then runs normally
    @(posedge clk);
    #1 hang_idx = nstarts;
    push(8'h11, 8'h22, 16'h0000, 1'b0);
    push(8'h02, 8'h03, 16'h0006, 1'b1);
    wait_for(1, "to_start");
    repeat (TIMEOUT) @(negedge clk);
    check("to_early", err_timeout, 0);
    @(negedge clk) check("to_flag", err_timeout, 1);
    @(negedge clk) check("to_next_start", mul_start, 1);
    check("to_next_m", mul_m, 8'h02);
    wait_for(2, "to_idle");
    check("to_drained", exp_q.size(), 0);
    check("err_sticky", err_timeout, 1);

    // Spurious done in IDLE
    @(posedge clk);
    #1 force_done = 1'b1;
    @(posedge clk);
    #1 force_done = 1'b0;
    @(negedge clk);
    check("sp_idle_busy", busy, 0);
    check("sp_idle_valid", out_valid, 0);
    check("sp_idle_product", out_product, 16'h0006);

    // Spurious done in OUT
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    push(8'h81, 8'h02, 16'hFF02, 1'b1);
    wait_for(0, "sp_out_valid");
    @(posedge clk);
    #1 force_done = 1'b1;
    @(posedge clk);
    #1 force_done = 1'b0;
    @(negedge clk);
    check("sp_out_valid_held", out_valid, 1);
    check("sp_out_product", out_product, 16'hFF02);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_for(2, "sp_idle");

    // Reset mid-WAIT with two queued entries
    @(posedge clk);
    #1 hang_idx = nstarts;
    push(8'h33, 8'h44, 16'h0000, 1'b0);
    push(8'h55, 8'h66, 16'h0000, 1'b0);
    push(8'h77, 8'h11, 16'h0000, 1'b0);
    @(negedge clk);
    check("rw_pre_full", in_ready, 0);
    check("rw_pre_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rw_start", mul_start, 0);
    check("rw_m", mul_m, 0);
    check("rw_q", mul_q, 0);
    check("rw_valid", out_valid, 0);
    check("rw_product", out_product, 0);
    check("rw_err", err_timeout, 0);
    check("rw_busy", busy, 0);
    check("rw_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rw_post_busy", busy, 0);
    check("rw_post_ready", in_ready, 1);
    check("rw_post_valid", out_valid, 0);

    // Normal operation after reset
    @(posedge clk);
    #1;
    push(8'hFE, 8'hFE, 16'h0004, 1'b1);
    wait_for(2, "final_idle");
    repeat (4) @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_op_sequencer.md
Name: booth_op_sequencer

Overview:
- Upstream/downstream wrapper stage for the N-bit Booth multiplier datapath and its controller.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one operation at a time: holds the operands stable, pulses start, waits for done, captures the 2N-bit product.
- Presents the product on an output valid/ready stream. A watchdog aborts any operation whose done never arrives.

Parameters:
- N, 8, operand width in bits (two's complement).
- DEPTH, 2, input FIFO entries (power of two, ≥2).
- TIMEOUT, 64, maximum cycles in WAIT before abort. Must exceed the multiplier's worst case, about 3N+3.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept
- in_mcand  in  N  multiplicand (M)
- in_mplier  in  N  multiplier (Q)
- mul_start  out  1  start pulse to the multiplier controller
- mul_m  out  N  multiplicand to the datapath, registered
- mul_q  out  N  multiplier to the datapath, registered
- mul_done  in  1  done from the multiplier controller (single-cycle pulse)
- mul_product  in  2N  {A,Q} product from the datapath, valid while mul_done=1
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts
- out_product  out  2N  captured product
- busy  out  1  state≠IDLE or FIFO non-empty
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO emptied; state=IDLE; counters cleared.
  - mul_start=0, mul_m=0, mul_q=0, out_valid=0, out_product=0, err_timeout=0, busy=0.
  - in_ready=1 after reset release.
  - Reset mid-operation discards the queued entries, the in-flight operation and any held result.
- FIFO:
  - in_ready = (count < DEPTH), combinational from count.
  - Push on in_valid & in_ready.
  - Pop only in IDLE when non-empty. Same-cycle push and pop keep count unchanged.
  - No push when full, even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT, OUT.
  - IDLE: if FIFO non-empty, pop the head into mul_m/mul_q and go to START. Else stay.
  - START: mul_start=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
  - WAIT: mul_start=0; counter increments each cycle.
    - If mul_done=1: register out_product ← mul_product, set out_valid=1, go to OUT.
    - Else if counter = TIMEOUT-1: set err_timeout=1, discard the operation, go to IDLE.
  - OUT: hold out_valid=1 and out_product stable until out_ready=1. On acceptance, out_valid=0 next cycle and go to IDLE.
- Operand hold:
  - mul_m/mul_q change only on a pop. They stay stable from START through WAIT and OUT.
  - This satisfies the controller's load, which occurs one cycle after start.
- mul_done outside WAIT is ignored. mul_done in the same cycle as the timeout limit: done wins, no error.
- err_timeout is sticky until reset.
- Latency, with the FIFO empty and out_ready=1:
  - push at cycle t → pop in IDLE at t+1 → START at t+2 → WAIT from t+3.
  - out_valid is asserted the cycle after mul_done.
- One operation in flight at a time. Maximum buffered operations = DEPTH queued + 1 in flight or held in OUT.
- Product format is passed through unchanged (2N-bit two's complement). No arithmetic in this block.

Test Plan:
- Single op, N=8, with a multiplier model: push M=8'h03, Q=8'hFC → mul_start one cycle high two cycles after the push; out_product=16'hFFF4 (−12); out_valid high until out_ready.
- Corner product: M=8'h80, Q=8'h80 → out_product=16'h4000; M=8'h7F, Q=8'h80 → 16'hC080.
- Backpressure: out_ready=0; push 4 pairs back-to-back → first three accepted (one in flight, two queued); in_ready=0 on the 4th; after out_ready=1, results emerge in push order with no loss or duplication.
- Timeout: model never asserts mul_done → after TIMEOUT cycles in WAIT, err_timeout=1 and the FSM returns to IDLE; next queued op completes normally; err_timeout stays 1.
- Spurious done: pulse mul_done in IDLE and in OUT → no state change, out_product unchanged.
- Reset mid-WAIT with 2 queued ops: rst_n low for 1 cycle → all outputs return to reset values immediately; FIFO empty; in_ready=1 after release; no stale result appears.
